// File: rtl/fir_filter.sv
// 32-tap block FIR: captures a 12-bit frame, emits one 29-bit output per clock.
// Define FIR_HISTORY_EN to stream previous-frame samples in place of zero history.
module fir_filter #(
   parameter logic [383:0] COEF = {32{12'sd64}}
) (
   input  logic               clk,
   input  logic               reset,
   input  logic signed [11:0] A0,
   input  logic signed [11:0] A1,
   input  logic signed [11:0] A2,
   input  logic signed [11:0] A3,
   input  logic signed [11:0] A4,
   input  logic signed [11:0] A5,
   input  logic signed [11:0] A6,
   input  logic signed [11:0] A7,
   input  logic signed [11:0] A8,
   input  logic signed [11:0] A9,
   input  logic signed [11:0] A10,
   input  logic signed [11:0] A11,
   input  logic signed [11:0] A12,
   input  logic signed [11:0] A13,
   input  logic signed [11:0] A14,
   input  logic signed [11:0] A15,
   input  logic signed [11:0] A16,
   input  logic signed [11:0] A17,
   input  logic signed [11:0] A18,
   input  logic signed [11:0] A19,
   input  logic signed [11:0] A20,
   input  logic signed [11:0] A21,
   input  logic signed [11:0] A22,
   input  logic signed [11:0] A23,
   input  logic signed [11:0] A24,
   input  logic signed [11:0] A25,
   input  logic signed [11:0] A26,
   input  logic signed [11:0] A27,
   input  logic signed [11:0] A28,
   input  logic signed [11:0] A29,
   input  logic signed [11:0] A30,
   input  logic signed [11:0] A31,
   output logic signed [28:0] B0,
   output logic signed [28:0] B1,
   output logic signed [28:0] B2,
   output logic signed [28:0] B3,
   output logic signed [28:0] B4,
   output logic signed [28:0] B5,
   output logic signed [28:0] B6,
   output logic signed [28:0] B7,
   output logic signed [28:0] B8,
   output logic signed [28:0] B9,
   output logic signed [28:0] B10,
   output logic signed [28:0] B11,
   output logic signed [28:0] B12,
   output logic signed [28:0] B13,
   output logic signed [28:0] B14,
   output logic signed [28:0] B15,
   output logic signed [28:0] B16,
   output logic signed [28:0] B17,
   output logic signed [28:0] B18,
   output logic signed [28:0] B19,
   output logic signed [28:0] B20,
   output logic signed [28:0] B21,
   output logic signed [28:0] B22,
   output logic signed [28:0] B23,
   output logic signed [28:0] B24,
   output logic signed [28:0] B25,
   output logic signed [28:0] B26,
   output logic signed [28:0] B27,
   output logic signed [28:0] B28,
   output logic signed [28:0] B29,
   output logic signed [28:0] B30,
   output logic signed [28:0] B31,
   output logic               done
);

   typedef enum logic {CAPTURE, COMPUTE} state_t;

   state_t state_q, state_d;
   logic [4:0] idx_q, idx_d;
   logic done_d;

   logic [383:0] a_flat;
   logic signed [11:0] x_q [32];
   logic signed [11:0] h [32];
   logic signed [11:0] ext [64];
   logic signed [28:0] b_q [32];
   logic signed [28:0] acc;
   logic signed [23:0] prod;
   logic [5:0] sel;

`ifdef FIR_HISTORY_EN
   logic signed [11:0] hx_q [32];
`endif

   assign a_flat = {A31, A30, A29, A28, A27, A26, A25, A24,
                    A23, A22, A21, A20, A19, A18, A17, A16,
                    A15, A14, A13, A12, A11, A10, A9, A8,
                    A7, A6, A5, A4, A3, A2, A1, A0};

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= CAPTURE;
         idx_q   <= '0;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         done    <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      done_d  = 1'b0;
      unique case (state_q)
         CAPTURE: begin
            state_d = COMPUTE;
            idx_d   = '0;
         end
         COMPUTE: begin
            idx_d = idx_q + 5'd1;
            if (idx_q == 5'd31) begin
               state_d = CAPTURE;
               idx_d   = '0;
               done_d  = 1'b1;
            end
         end
         default: state_d = CAPTURE;
      endcase
   end

   // ext[32+m] holds x[m]; ext[1..31] hold samples with m < 0
   always_comb begin
      for (int i = 0; i < 32; i++) begin
         h[i] = COEF[12*i +: 12];
`ifdef FIR_HISTORY_EN
         ext[i] = hx_q[i];
`else
         ext[i] = '0;
`endif
         ext[i+32] = x_q[i];
      end
   end

   always_comb begin
      acc  = '0;
      prod = '0;
      sel  = '0;
      for (int k = 0; k < 32; k++) begin
         sel  = 6'(idx_q) + 6'd32 - 6'(k);
         prod = 24'(h[k]) * 24'(ext[sel]);
         acc  = acc + 29'(prod);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         x_q <= '{default: '0};
         b_q <= '{default: '0};
`ifdef FIR_HISTORY_EN
         hx_q <= '{default: '0};
`endif
      end else if (state_q == CAPTURE) begin
         for (int i = 0; i < 32; i++)
            x_q[i] <= a_flat[12*i +: 12];
`ifdef FIR_HISTORY_EN
         hx_q <= x_q;
`endif
      end else begin
         b_q[idx_q] <= acc;
      end
   end

   assign B0  = b_q[0];
   assign B1  = b_q[1];
   assign B2  = b_q[2];
   assign B3  = b_q[3];
   assign B4  = b_q[4];
   assign B5  = b_q[5];
   assign B6  = b_q[6];
   assign B7  = b_q[7];
   assign B8  = b_q[8];
   assign B9  = b_q[9];
   assign B10 = b_q[10];
   assign B11 = b_q[11];
   assign B12 = b_q[12];
   assign B13 = b_q[13];
   assign B14 = b_q[14];
   assign B15 = b_q[15];
   assign B16 = b_q[16];
   assign B17 = b_q[17];
   assign B18 = b_q[18];
   assign B19 = b_q[19];
   assign B20 = b_q[20];
   assign B21 = b_q[21];
   assign B22 = b_q[22];
   assign B23 = b_q[23];
   assign B24 = b_q[24];
   assign B25 = b_q[25];
   assign B26 = b_q[26];
   assign B27 = b_q[27];
   assign B28 = b_q[28];
   assign B29 = b_q[29];
   assign B30 = b_q[30];
   assign B31 = b_q[31];

endmodule

// File: tb/tb_fir_filter.sv
// Random-frame bench for fir_filter against a direct convolution model.
// Taps are h[k] = k+1 so any mis-sliced coefficient shows up.
module tb_fir_filter;

   function automatic logic [383:0] ramp();
      logic [383:0] r;
      for (int k = 0; k < 32; k++)
         r[12*k +: 12] = 12'(k + 1);
      return r;
   endfunction

   localparam logic [383:0] TB_COEF = ramp();

   logic clk;
   logic reset;
   logic signed [11:0] a [32];
   logic signed [28:0] b [32];
   logic done;

   int n_cmp;
   int n_bad;
   int prev [32];

   fir_filter #(.COEF(TB_COEF)) dut (
      .clk(clk), .reset(reset),
      .A0(a[0]), .A1(a[1]), .A2(a[2]), .A3(a[3]),
      .A4(a[4]), .A5(a[5]), .A6(a[6]), .A7(a[7]),
      .A8(a[8]), .A9(a[9]), .A10(a[10]), .A11(a[11]),
      .A12(a[12]), .A13(a[13]), .A14(a[14]), .A15(a[15]),
      .A16(a[16]), .A17(a[17]), .A18(a[18]), .A19(a[19]),
      .A20(a[20]), .A21(a[21]), .A22(a[22]), .A23(a[23]),
      .A24(a[24]), .A25(a[25]), .A26(a[26]), .A27(a[27]),
      .A28(a[28]), .A29(a[29]), .A30(a[30]), .A31(a[31]),
      .B0(b[0]), .B1(b[1]), .B2(b[2]), .B3(b[3]),
      .B4(b[4]), .B5(b[5]), .B6(b[6]), .B7(b[7]),
      .B8(b[8]), .B9(b[9]), .B10(b[10]), .B11(b[11]),
      .B12(b[12]), .B13(b[13]), .B14(b[14]), .B15(b[15]),
      .B16(b[16]), .B17(b[17]), .B18(b[18]), .B19(b[19]),
      .B20(b[20]), .B21(b[21]), .B22(b[22]), .B23(b[23]),
      .B24(b[24]), .B25(b[25]), .B26(b[26]), .B27(b[27]),
      .B28(b[28]), .B29(b[29]), .B30(b[30]), .B31(b[31]),
      .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input longint got,
                      input longint exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // y[n] = sum_k (k+1) * x[n-k]; x[m<0] from previous frame or zero
   function automatic void model(input int fr[32], output int e[32]);
      int v;
      for (int n = 0; n < 32; n++) begin
         e[n] = 0;
         for (int k = 0; k < 32; k++) begin
            if (n - k >= 0) v = fr[n-k];
`ifdef FIR_HISTORY_EN
            else v = prev[n-k+32];
`else
            else v = 0;
`endif
            e[n] += (k + 1) * v;
         end
      end
   endfunction

   task automatic rand_frame(output int fr[32]);
      logic signed [11:0] t;
      for (int i = 0; i < 32; i++) begin
         t = 12'($urandom);
         fr[i] = int'(t);
      end
   endtask

   task automatic run_block(input int fr[32], input bit scramble);
      int e[32];
      for (int i = 0; i < 32; i++) a[i] = 12'(fr[i]);
      model(fr, e);
      tick();
      chk("done_capture", longint'(done), 0);
      for (int n = 0; n < 32; n++) begin
         if (scramble)
            for (int i = 0; i < 32; i++) a[i] = 12'($urandom);
         tick();
         chk($sformatf("b%0d", n), longint'(b[n]), longint'(e[n]));
         chk($sformatf("done_e%0d", n + 2), longint'(done),
             longint'(n == 31));
      end
      prev = fr;
   endtask

   initial begin
      int f[32];
      n_cmp = 0;
      n_bad = 0;
      prev = '{default: 0};
      reset = 1'b1;
      for (int i = 0; i < 32; i++) a[i] = 12'($urandom);
      repeat (3) tick();
      for (int i = 0; i < 32; i++)
         chk($sformatf("rst_b%0d", i), longint'(b[i]), 0);
      chk("rst_done", longint'(done), 0);
      reset = 1'b0;

      f = '{default: 1};
      run_block(f, 1'b0);
      chk("ones_b31", longint'(b[31]), 528);

      f = '{default: -2048};
      run_block(f, 1'b0);
`ifndef FIR_HISTORY_EN
      chk("neg_b31", longint'(b[31]), -1081344);
`endif

      f = '{default: 0};
      f[0] = 1;
      run_block(f, 1'b0);

      for (int r = 0; r < 4; r++) begin
         rand_frame(f);
         run_block(f, 1'b1);
      end

      f = '{default: 1};
      run_block(f, 1'b0);
      run_block(f, 1'b0);

      rand_frame(f);
      for (int i = 0; i < 32; i++) a[i] = 12'(f[i]);
      repeat (9) tick();
      reset = 1'b1;
      tick();
      for (int i = 0; i < 32; i++)
         chk($sformatf("abort_b%0d", i), longint'(b[i]), 0);
      chk("abort_done", longint'(done), 0);
      tick();
      chk("abort_done2", longint'(done), 0);
      reset = 1'b0;
      prev = '{default: 0};

      rand_frame(f);
      run_block(f, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
